exu_wb_arb: RTL and testbench

//  Writeback arbiter; receiving end of the EXU result interface (result/reg_we/reg_waddr).

---
 rtl/exu_wb_arb_if.sv | 38 +++
 rtl/exu_wb_arb.sv | 100 ++++++++++
 tb/tb_exu_wb_arb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/exu_wb_arb_if.sv
// exu_wb_arb_if: EXU result bus into the writeback arbiter. The forwarding lookup exists only when WB_FWD_EN is defined.
interface exu_wb_arb_if;
   logic        flush_i;
   logic        alu_reg_we_i;
   logic [4:0]  alu_reg_waddr_i;
   logic [31:0] alu_result_i;
   logic        alu_stall_o;
   logic        ext_valid_i;
   logic        ext_ready_o;
   logic [4:0]  ext_waddr_i;
   logic [31:0] ext_data_i;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
`ifdef WB_FWD_EN
   logic [4:0]  fwd_raddr_i;
   logic        fwd_hit_o;
   logic [31:0] fwd_data_o;
`endif
   modport slave (
`ifdef WB_FWD_EN
      input fwd_raddr_i,
      output fwd_hit_o, fwd_data_o,
`endif
      input flush_i, alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
      input ext_valid_i, ext_waddr_i, ext_data_i,
      output alu_stall_o, ext_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o
   );
   modport master (
`ifdef WB_FWD_EN
      output fwd_raddr_i,
      input fwd_hit_o, fwd_data_o,
`endif
      output flush_i, alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
      output ext_valid_i, ext_waddr_i, ext_data_i,
      input alu_stall_o, ext_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o
   );
endinterface

// File: rtl/exu_wb_arb.sv
// exu_wb_arb: writeback arbiter merging the ALU and multi-cycle result ports onto one GPR write port.
// Define WB_FWD_EN to add a forwarding lookup over pending results.
module exu_wb_arb #(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_LIM = 4
) (
   input logic        clk,
   input logic        rst,
   exu_wb_arb_if.slave wb
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [4:0]    fifo_waddr_q [FIFO_DEPTH];
   logic [31:0]   fifo_data_q  [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          reg_we_q, reg_we_d;
   logic [4:0]    reg_waddr_q, reg_waddr_d;
   logic [31:0]   reg_wdata_q, reg_wdata_d;
   logic          empty, starved, alu_req, alu_win, ext_ok, ext_hs, bypass, pop, push;

   always_comb begin
      empty          = count_q == '0;
      alu_req        = wb.alu_reg_we_i & (wb.alu_reg_waddr_i != '0);
      starved        = (starve_q == SW'(STARVE_LIM)) & ~empty & ~wb.flush_i;
      wb.alu_stall_o = starved;
      wb.ext_ready_o = (count_q < CW'(FIFO_DEPTH)) & ~wb.flush_i;
      ext_ok         = wb.ext_waddr_i != '0;
      ext_hs         = wb.ext_valid_i & wb.ext_ready_o;
      pop            = ~wb.flush_i & ~empty & (starved | ~alu_req);
      alu_win        = alu_req & ~starved;
      bypass         = ext_hs & empty & ~alu_req;
      // x0 results finish the handshake but are neither queued nor written
      push           = ext_hs & ext_ok & ~bypass;
      reg_we_d       = pop | alu_win | (bypass & ext_ok);
      reg_waddr_d    = pop ? fifo_waddr_q[rd_ptr_q] : alu_win ? wb.alu_reg_waddr_i :
                       (bypass & ext_ok) ? wb.ext_waddr_i : reg_waddr_q;
      reg_wdata_d    = pop ? fifo_data_q[rd_ptr_q] : alu_win ? wb.alu_result_i :
                       (bypass & ext_ok) ? wb.ext_data_i : reg_wdata_q;
      rd_ptr_d       = wb.flush_i ? '0 : rd_ptr_q + AW'(pop);
      wr_ptr_d       = wb.flush_i ? '0 : wr_ptr_q + AW'(push);
      count_d        = wb.flush_i ? '0 : count_q + CW'(push) - CW'(pop);
      starve_d       = (wb.flush_i | empty | pop) ? '0 :
                       (alu_win & (starve_q != SW'(STARVE_LIM))) ? starve_q + 1'b1 : starve_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_waddr_q[wr_ptr_q] <= wb.ext_waddr_i;
         fifo_data_q[wr_ptr_q]  <= wb.ext_data_i;
      end
   end

   assign wb.reg_we_o    = reg_we_q;
   assign wb.reg_waddr_o = reg_waddr_q;
   assign wb.reg_wdata_o = reg_wdata_q;

`ifdef WB_FWD_EN
   // scan oldest to newest so the youngest match overrides
   always_comb begin
      wb.fwd_hit_o  = 1'b0;
      wb.fwd_data_o = '0;
      if (wb.fwd_raddr_i != '0) begin
         if (reg_we_q && reg_waddr_q == wb.fwd_raddr_i) begin
            wb.fwd_hit_o  = 1'b1;
            wb.fwd_data_o = reg_wdata_q;
         end
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (CW'(k) < count_q && fifo_waddr_q[rd_ptr_q + AW'(k)] == wb.fwd_raddr_i) begin
               wb.fwd_hit_o  = 1'b1;
               wb.fwd_data_o = fifo_data_q[rd_ptr_q + AW'(k)];
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_exu_wb_arb.sv
// tb_exu_wb_arb: directed vectors for exu_wb_arb with hand-computed expectations (FIFO_DEPTH=4, STARVE_LIM=4).
module tb_exu_wb_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   exu_wb_arb_if wb();
   exu_wb_arb #(.FIFO_DEPTH(4), .STARVE_LIM(4)) dut (.clk(clk), .rst(rst), .wb(wb));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb.alu_reg_we_i    = we;
      wb.alu_reg_waddr_i = a;
      wb.alu_result_i    = d;
   endtask

   task automatic ext(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb.ext_valid_i = v;
      wb.ext_waddr_i = a;
      wb.ext_data_i  = d;
   endtask

   task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
      check({tag, "_we"}, wb.reg_we_o, 1);
      check({tag, "_waddr"}, wb.reg_waddr_o, a);
      check({tag, "_wdata"}, wb.reg_wdata_o, d);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      wb.flush_i = 1'b0;
      alu(0, 0, 0);
      ext(0, 0, 0);
`ifdef WB_FWD_EN
      wb.fwd_raddr_i = '0;
`endif
      tick;
      tick;
      rst = 1'b0;
      #1;
      check("rst_we", wb.reg_we_o, 0);
      check("rst_waddr", wb.reg_waddr_o, 0);
      check("rst_wdata", wb.reg_wdata_o, 0);
      check("rst_ready", wb.ext_ready_o, 1);
      check("rst_stall", wb.alu_stall_o, 0);

      alu(1, 5, 32'h1234);
      tick;
      expect_wr("alu", 5, 32'h1234);
      alu(0, 0, 0);
      tick;
      check("alu_idle_we", wb.reg_we_o, 0);
      check("alu_idle_hold", wb.reg_waddr_o, 5);

      ext(1, 7, 32'hA5A5A5A5);
      #1 check("byp_ready", wb.ext_ready_o, 1);
      tick;
      ext(0, 0, 0);
      expect_wr("byp", 7, 32'hA5A5A5A5);
      tick;
      check("byp_not_queued", wb.reg_we_o, 0);

      alu(1, 10, 100);
      ext(1, 9, 32'h99);
      tick;
      ext(0, 0, 0);
      expect_wr("st0", 10, 100);
      for (int i = 1; i <= 4; i++) begin
         alu(1, 10, 32'(100 + i));
         #1 check("st_nostall", wb.alu_stall_o, 0);
         tick;
         expect_wr("st_alu", 10, 32'(100 + i));
      end
      alu(1, 10, 105);
      #1 check("st_stall", wb.alu_stall_o, 1);
      tick;
      expect_wr("st_ext", 9, 32'h99);
      check("st_resume_nostall", wb.alu_stall_o, 0);
      tick;
      expect_wr("st_resume", 10, 105);
      alu(0, 0, 0);
      tick;
      check("st_idle", wb.reg_we_o, 0);

      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            alu(1, 20, 32'(200 + k));
            ext(1, 5'(r * 10 + k + 1), 32'(32'h1000 + r * 16 + k));
            #1 check("full_ready", wb.ext_ready_o, 1);
            tick;
            expect_wr("full_alu", 20, 32'(200 + k));
         end
         alu(0, 0, 0);
         ext(1, 31, 32'hBAD);
         #1 check("full_notready", wb.ext_ready_o, 0);
         for (int k = 0; k < 4; k++) begin
            tick;
            ext(0, 0, 0);
            expect_wr("drain", 5'(r * 10 + k + 1), 32'(32'h1000 + r * 16 + k));
         end
         tick;
         check("drain_done", wb.reg_we_o, 0);
      end

      ext(1, 0, 32'hDEAD);
      #1 check("x0_ready", wb.ext_ready_o, 1);
      tick;
      ext(0, 0, 0);
      check("x0_ext_nowrite", wb.reg_we_o, 0);
      alu(1, 0, 55);
      tick;
      alu(0, 0, 0);
      check("x0_alu_nowrite", wb.reg_we_o, 0);
      alu(1, 6, 66);
      ext(1, 0, 77);
      tick;
      alu(0, 0, 0);
      ext(0, 0, 0);
      expect_wr("x0_alu", 6, 66);
      tick;
      check("x0_not_queued", wb.reg_we_o, 0);

      for (int c = 0; c < 5; c++) begin
         alu(1, 25, 32'(300 + c));
         ext(c < 3, 5'(21 + c), 32'(32'h2100 + c));
         tick;
         expect_wr("fl_alu", 25, 32'(300 + c));
      end
      alu(1, 30, 32'h300);
      ext(1, 24, 32'h2400);
      wb.flush_i = 1'b1;
      #1 check("fl_stall", wb.alu_stall_o, 0);
      check("fl_ready", wb.ext_ready_o, 0);
      tick;
      wb.flush_i = 1'b0;
      alu(0, 0, 0);
      ext(0, 0, 0);
      expect_wr("fl_alu_lands", 30, 32'h300);
      tick;
      check("fl_empty", wb.reg_we_o, 0);
      tick;
      check("fl_empty2", wb.reg_we_o, 0);

      alu(1, 12, 32'h120);
      ext(1, 13, 32'h130);
      tick;
      ext(1, 14, 32'h140);
      tick;
      alu(0, 0, 0);
      ext(0, 0, 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("mrst_we", wb.reg_we_o, 0);
      check("mrst_ready", wb.ext_ready_o, 1);
      tick;
      check("mrst_discard", wb.reg_we_o, 0);

`ifdef WB_FWD_EN
      alu(1, 8, 32'h88);
      ext(1, 3, 32'h11);
      tick;
      ext(1, 3, 32'h22);
      tick;
      alu(0, 0, 0);
      ext(0, 0, 0);
      wb.fwd_raddr_i = 3;
      #1 check("fwd_hit", wb.fwd_hit_o, 1);
      check("fwd_young", wb.fwd_data_o, 32'h22);
      wb.fwd_raddr_i = 8;
      #1 check("fwd_out_hit", wb.fwd_hit_o, 1);
      check("fwd_out_data", wb.fwd_data_o, 32'h88);
      wb.fwd_raddr_i = 0;
      #1 check("fwd_x0_hit", wb.fwd_hit_o, 0);
      check("fwd_x0_data", wb.fwd_data_o, 0);
      tick;
      expect_wr("fwd_drain0", 3, 32'h11);
      tick;
      expect_wr("fwd_drain1", 3, 32'h22);
      tick;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
